// File: rtl/pl_pkg.sv
// Shared definitions for the pipeline hazard controller: result-select and
// forward-select encodings, the load-use FSM states, and the control bundle.
package pl_pkg;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_LU_WAIT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hz_ctrl_t;

  // A load in execute whose destination feeds the instruction in decode.
  // x0 never carries a dependency.
  function automatic logic load_use(input logic [1:0] result_src_e,
                                    input logic [4:0] rd_e,
                                    input logic [4:0] rs1_d,
                                    input logic [4:0] rs2_d);
    return (result_src_e == RESULT_SRC_LOAD) && (rd_e != 5'd0) &&
           ((rd_e == rs1_d) || (rd_e == rs2_d));
  endfunction

endpackage

// File: rtl/pl_fwd_sel.sv
// Forward-select for one execute-stage operand. The memory-stage result is
// newer than the writeback result, so it wins when both match.
module pl_fwd_sel
  import pl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       regwrite_m,
  input  logic [4:0] rd_w,
  input  logic       regwrite_w,
  output logic [1:0] sel
);

  // Pick the youngest in-flight producer of rs, ignoring x0.
  always_comb begin
    sel = FWD_RF;
    if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pl_hazard_unit.sv
// Pipeline hazard controller for the 5-stage core. Drives the hold (stall)
// and clear-to-bubble (flush) controls of every pipeline register in the
// same cycle, sequences multi-cycle load-use bubbles and counts stall/flush
// cycles. LOAD_BUBBLES is meaningful in the range 1..7.
module pl_hazard_unit
  import pl_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       Result_srcE,
  input  logic [4:0]       RdM,
  input  logic             regwriteM,
  input  logic [4:0]       RdW,
  input  logic             regwriteW,
  input  logic             PCSrcE,
  input  logic             MemBusyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  // Bubbles still owed after the one inserted in the hazard-detect cycle.
  localparam logic [2:0] LU_RELOAD = 3'(LOAD_BUBBLES - 1);
  localparam bit         LU_MULTI  = (LOAD_BUBBLES > 1);

  hz_state_e  state_r;
  hz_state_e  next_state_s;
  logic [2:0] bub_cnt_r;
  logic [2:0] next_bub_cnt_s;
  logic       lu_hazard_s;
  hz_ctrl_t   ctrl_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  assign lu_hazard_s = load_use(Result_srcE, RdE, Rs1D, Rs2D);

  pl_fwd_sel u_fwd_a (
    .rs         (Rs1E),
    .rd_m       (RdM),
    .regwrite_m (regwriteM),
    .rd_w       (RdW),
    .regwrite_w (regwriteW),
    .sel        (fwd_a_s)
  );

  pl_fwd_sel u_fwd_b (
    .rs         (Rs2E),
    .rd_m       (RdM),
    .regwrite_m (regwriteM),
    .rd_w       (RdW),
    .regwrite_w (regwriteW),
    .sel        (fwd_b_s)
  );

  // State register and bubble down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_RUN;
      bub_cnt_r <= 3'd0;
    end else begin
      state_r   <= next_state_s;
      bub_cnt_r <= next_bub_cnt_s;
    end
  end

  // Next-state logic: a memory freeze holds everything, a redirect aborts
  // any pending bubbles, otherwise the load-use sequence runs.
  always_comb begin
    next_state_s   = state_r;
    next_bub_cnt_s = bub_cnt_r;
    if (MemBusyM) begin
      next_state_s   = state_r;
      next_bub_cnt_s = bub_cnt_r;
    end else if (PCSrcE) begin
      next_state_s   = ST_RUN;
      next_bub_cnt_s = 3'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (lu_hazard_s && LU_MULTI) begin
            next_state_s   = ST_LU_WAIT;
            next_bub_cnt_s = LU_RELOAD;
          end else begin
            next_state_s   = ST_RUN;
            next_bub_cnt_s = 3'd0;
          end
        end
        ST_LU_WAIT: begin
          if (bub_cnt_r <= 3'd1) begin
            next_state_s   = ST_RUN;
            next_bub_cnt_s = 3'd0;
          end else begin
            next_state_s   = ST_LU_WAIT;
            next_bub_cnt_s = bub_cnt_r - 3'd1;
          end
        end
        default: begin
          next_state_s   = ST_RUN;
          next_bub_cnt_s = 3'd0;
        end
      endcase
    end
  end

  // Output decode by priority; reset forces bubbles into D and E so nothing
  // issues while the core is held.
  always_comb begin
    ctrl_s = '0;
    if (reset) begin
      ctrl_s.flush_d = 1'b1;
      ctrl_s.flush_e = 1'b1;
    end else if (MemBusyM) begin
      ctrl_s.stall_f = 1'b1;
      ctrl_s.stall_d = 1'b1;
      ctrl_s.stall_e = 1'b1;
      ctrl_s.stall_m = 1'b1;
      ctrl_s.flush_w = 1'b1;
    end else if (PCSrcE) begin
      ctrl_s.flush_d = 1'b1;
      ctrl_s.flush_e = 1'b1;
    end else if ((state_r == ST_LU_WAIT) || lu_hazard_s) begin
      ctrl_s.stall_f = 1'b1;
      ctrl_s.stall_d = 1'b1;
      ctrl_s.flush_e = 1'b1;
    end else begin
      ctrl_s = '0;
    end
  end

  assign StallF    = ctrl_s.stall_f;
  assign StallD    = ctrl_s.stall_d;
  assign StallE    = ctrl_s.stall_e;
  assign StallM    = ctrl_s.stall_m;
  assign FlushD    = ctrl_s.flush_d;
  assign FlushE    = ctrl_s.flush_e;
  assign FlushW    = ctrl_s.flush_w;
  assign ForwardAE = reset ? FWD_RF : fwd_a_s;
  assign ForwardBE = reset ? FWD_RF : fwd_b_s;

  // Performance counters: fetch-stall cycles and execute-flush cycles,
  // wrapping at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (ctrl_s.stall_f) begin
        StallCnt <= StallCnt + CNT_W'(1);
      end
      if (ctrl_s.flush_e) begin
        FlushCnt <= FlushCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pl_hazard_unit.sv
// Self-checking bench for pl_hazard_unit. Two instances (LOAD_BUBBLES = 1
// and 3) share stimulus; each is compared every cycle against a model that
// tracks the number of owed bubbles and counter totals.
module tb_pl_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] Result_srcE;
  logic       regwriteM, regwriteW, PCSrcE, MemBusyM;

  logic [1:0]        sf_o, sd_o, se_o, sm_o, fd_o, fe_o, fw_o;
  logic [1:0][1:0]   fa_o, fb_o;
  logic [1:0][31:0]  sc_o, fc_o;

  int         checks = 0;
  int         errors = 0;
  int         lbv [2] = '{1, 3};
  int         rem [2];
  logic [31:0] msc [2];
  logic [31:0] mfc [2];

  always #5 clk = ~clk;

  pl_hazard_unit #(.LOAD_BUBBLES(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .Result_srcE(Result_srcE), .RdM(RdM), .regwriteM(regwriteM),
    .RdW(RdW), .regwriteW(regwriteW), .PCSrcE(PCSrcE), .MemBusyM(MemBusyM),
    .StallF(sf_o[0]), .StallD(sd_o[0]), .StallE(se_o[0]), .StallM(sm_o[0]),
    .FlushD(fd_o[0]), .FlushE(fe_o[0]), .FlushW(fw_o[0]),
    .ForwardAE(fa_o[0]), .ForwardBE(fb_o[0]), .StallCnt(sc_o[0]), .FlushCnt(fc_o[0])
  );

  pl_hazard_unit #(.LOAD_BUBBLES(3), .CNT_W(32)) dut3 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .Result_srcE(Result_srcE), .RdM(RdM), .regwriteM(regwriteM),
    .RdW(RdW), .regwriteW(regwriteW), .PCSrcE(PCSrcE), .MemBusyM(MemBusyM),
    .StallF(sf_o[1]), .StallD(sd_o[1]), .StallE(se_o[1]), .StallM(sm_o[1]),
    .FlushD(fd_o[1]), .FlushE(fe_o[1]), .FlushW(fw_o[1]),
    .ForwardAE(fa_o[1]), .ForwardBE(fb_o[1]), .StallCnt(sc_o[1]), .FlushCnt(fc_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic hazard();
    return (Result_srcE == 2'b01) && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
  endfunction

  // Expected controls {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
  function automatic logic [6:0] exp_ctrl(input int k);
    if (reset)                       return 7'b0000_110;
    else if (MemBusyM)               return 7'b1111_001;
    else if (PCSrcE)                 return 7'b0000_110;
    else if (rem[k] > 0 || hazard()) return 7'b1100_010;
    else                             return 7'b0000_000;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (reset) return 2'b00;
    if (regwriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
    if (regwriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_cycle(input string ph);
    logic [6:0] e;
    for (int k = 0; k < 2; k++) begin
      e = exp_ctrl(k);
      chk($sformatf("%s.lb%0d.StallF", ph, lbv[k]), {31'd0, sf_o[k]}, {31'd0, e[6]});
      chk($sformatf("%s.lb%0d.StallD", ph, lbv[k]), {31'd0, sd_o[k]}, {31'd0, e[5]});
      chk($sformatf("%s.lb%0d.StallE", ph, lbv[k]), {31'd0, se_o[k]}, {31'd0, e[4]});
      chk($sformatf("%s.lb%0d.StallM", ph, lbv[k]), {31'd0, sm_o[k]}, {31'd0, e[3]});
      chk($sformatf("%s.lb%0d.FlushD", ph, lbv[k]), {31'd0, fd_o[k]}, {31'd0, e[2]});
      chk($sformatf("%s.lb%0d.FlushE", ph, lbv[k]), {31'd0, fe_o[k]}, {31'd0, e[1]});
      chk($sformatf("%s.lb%0d.FlushW", ph, lbv[k]), {31'd0, fw_o[k]}, {31'd0, e[0]});
      chk($sformatf("%s.lb%0d.ForwardAE", ph, lbv[k]), {30'd0, fa_o[k]}, {30'd0, exp_fwd(Rs1E)});
      chk($sformatf("%s.lb%0d.ForwardBE", ph, lbv[k]), {30'd0, fb_o[k]}, {30'd0, exp_fwd(Rs2E)});
      chk($sformatf("%s.lb%0d.StallCnt", ph, lbv[k]), sc_o[k], reset ? 32'd0 : msc[k]);
      chk($sformatf("%s.lb%0d.FlushCnt", ph, lbv[k]), fc_o[k], reset ? 32'd0 : mfc[k]);
    end
  endtask

  // Advance the model across one rising edge using the inputs held there.
  task automatic advance();
    logic [6:0] e;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      e = exp_ctrl(k);
      if (reset) begin
        rem[k] = 0;
        msc[k] = 32'd0;
        mfc[k] = 32'd0;
      end else begin
        if (e[6]) msc[k] = msc[k] + 32'd1;
        if (e[1]) mfc[k] = mfc[k] + 32'd1;
        if (MemBusyM)        rem[k] = rem[k];
        else if (PCSrcE)     rem[k] = 0;
        else if (rem[k] > 0) rem[k] = rem[k] - 1;
        else if (hazard())   rem[k] = lbv[k] - 1;
      end
    end
    #1;
  endtask

  task automatic step(input string ph);
    #1;
    check_cycle(ph);
    advance();
  endtask

  task automatic idle_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
    RdM = 5'd0; RdW = 5'd0; Result_srcE = 2'b00; regwriteM = 1'b0;
    regwriteW = 1'b0; PCSrcE = 1'b0; MemBusyM = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; msc[k] = 32'd0; mfc[k] = 32'd0;
    end
    reset = 1'b1;
    idle_inputs();
    #12;
    check_cycle("reset");
    advance();
    reset = 1'b0;
    step("idle");

    // Load-use: lw x5 in E, Rs1D = 5, hazard dropped after one cycle.
    Result_srcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5;
    step("lu_c1");
    Result_srcE = 2'b00;
    step("lu_c2");
    step("lu_c3");
    step("lu_c4");
    step("lu_c5");

    // Redirect arriving in the second cycle of a load-use sequence.
    Result_srcE = 2'b01; RdE = 5'd5; Rs2D = 5'd5; Rs1D = 5'd1;
    step("redir_c1");
    Result_srcE = 2'b00; PCSrcE = 1'b1;
    step("redir_c2");
    PCSrcE = 1'b0;
    step("redir_c3");

    // Memory freeze over a pending redirect.
    MemBusyM = 1'b1; PCSrcE = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("busy_c%0d", i));
    MemBusyM = 1'b0;
    step("busy_exit");
    PCSrcE = 1'b0;
    step("busy_after");

    // Forwarding priority and x0 handling.
    regwriteM = 1'b1; regwriteW = 1'b1; RdM = 5'd7; RdW = 5'd7; Rs1E = 5'd7; Rs2E = 5'd3;
    step("fwd_mem_prio");
    RdM = 5'd0; RdW = 5'd0; Rs2E = 5'd0;
    step("fwd_x0");
    RdM = 5'd4; RdW = 5'd9; Rs2E = 5'd9;
    step("fwd_wb");
    idle_inputs();

    // Asynchronous reset in the middle of LU_WAIT.
    Result_srcE = 2'b01; RdE = 5'd6; Rs1D = 5'd6;
    step("rst_lu");
    Result_srcE = 2'b00;
    #2;
    reset = 1'b1;
    #1;
    check_cycle("rst_mid");
    advance();
    reset = 1'b0;
    step("rst_post1");
    step("rst_post2");

    // Randomised traffic over a small register window to provoke matches.
    for (int i = 0; i < 400; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      Result_srcE = 2'($urandom_range(0, 3));
      regwriteM = 1'($urandom_range(0, 1)); regwriteW = 1'($urandom_range(0, 1));
      PCSrcE   = ($urandom_range(0, 5) == 0);
      MemBusyM = ($urandom_range(0, 7) == 0);
      reset    = ($urandom_range(0, 99) == 0);
      step($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
